// File: rtl/reg_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_file_sb : 2^D x W register file, dual read/write, pending scoreboard,  |
// | and a one-entry-per-cycle clear sweep.                     Revision: 1.0  |
// +--------------------------------------------------------------------------+
module reg_file_sb #(
   parameter int W        = 8,
   parameter int D        = 3,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         we_a_i,
   input  logic [D-1:0] waddr_a_i,
   input  logic [W-1:0] wdata_a_i,
   input  logic         we_b_i,
   input  logic [D-1:0] waddr_b_i,
   input  logic [W-1:0] wdata_b_i,
   input  logic [D-1:0] raddr_a_i,
   input  logic [D-1:0] raddr_b_i,
   output logic [W-1:0] out_a_o,
   output logic [W-1:0] out_b_o,
   input  logic         reserve_en_i,
   input  logic [D-1:0] reserve_addr_i,
   output logic         busy_a_o,
   output logic         busy_b_o,
   input  logic         clear_req_i,
   output logic         clear_busy_o
);

   localparam int DEPTH = 1 << D;
   localparam bit C_ZR  = (ZERO_REG != 0);
   localparam bit C_BYP = (BYPASS != 0);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_e;

   state_e             state_q;
   logic [D-1:0]       idx_q;
   logic               clear_busy_q;
   logic [W-1:0]       mem_q [DEPTH];
   logic [W-1:0]       mem_d [DEPTH];
   logic [DEPTH-1:0]   pend_q;
   logic [DEPTH-1:0]   pend_d;

   logic               w_sweep;
   logic               w_wa_ok;
   logic               w_wb_ok;
   logic               w_res_ok;

   assign w_sweep  = (state_q == ST_SWEEP);
   // r0 accepts nothing when hardwired to zero, so its pending bit can never set.
   assign w_wa_ok  = we_a_i & ~w_sweep & ~(C_ZR && (waddr_a_i == '0));
   assign w_wb_ok  = we_b_i & ~w_sweep & ~(C_ZR && (waddr_b_i == '0));
   assign w_res_ok = reserve_en_i & ~w_sweep & ~(C_ZR && (reserve_addr_i == '0));

   always_comb begin
      mem_d  = mem_q;
      pend_d = pend_q;
      if (w_sweep) begin
         mem_d[idx_q]  = '0;
         pend_d[idx_q] = 1'b0;
         if (idx_q == '1) begin
            pend_d = '0;
         end
      end else begin
         // B applied first so A overwrites it on an address collision.
         if (w_wb_ok) begin
            mem_d[waddr_b_i]  = wdata_b_i;
            pend_d[waddr_b_i] = 1'b0;
         end
         if (w_wa_ok) begin
            mem_d[waddr_a_i]  = wdata_a_i;
            pend_d[waddr_a_i] = 1'b0;
         end
         if (w_res_ok) begin
            pend_d[reserve_addr_i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         pend_q       <= '0;
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         clear_busy_q <= 1'b0;
      end else begin
         mem_q  <= mem_d;
         pend_q <= pend_d;
         case (state_q)
            ST_IDLE: begin
               if (clear_req_i) begin
                  state_q      <= ST_SWEEP;
                  idx_q        <= '0;
                  clear_busy_q <= 1'b1;
               end
            end
            ST_SWEEP: begin
               idx_q <= idx_q + 1'b1;
               if (idx_q == '1) begin
                  state_q      <= ST_IDLE;
                  clear_busy_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               clear_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign clear_busy_o = clear_busy_q;

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [D-1:0] w_raddr;
      logic [W-1:0] w_out;
      logic         w_busy;

      assign w_raddr = (p == 0) ? raddr_a_i : raddr_b_i;

      always_comb begin
         w_out  = mem_q[w_raddr];
         w_busy = pend_q[w_raddr];
         if (C_BYP) begin
            if (w_wa_ok && (waddr_a_i == w_raddr)) begin
               w_out  = wdata_a_i;
               w_busy = 1'b0;
            end else if (w_wb_ok && (waddr_b_i == w_raddr)) begin
               w_out  = wdata_b_i;
               w_busy = 1'b0;
            end
         end
         if (C_ZR && (w_raddr == '0)) begin
            w_out  = '0;
            w_busy = 1'b0;
         end
      end
   end

   assign out_a_o  = g_rd[0].w_out;
   assign out_b_o  = g_rd[1].w_out;
   assign busy_a_o = g_rd[0].w_busy;
   assign busy_b_o = g_rd[1].w_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// tb_reg_file_sb : directed vectors against three parameterisations
// (bypass, no bypass, hardwired r0) sharing one stimulus stream.
module tb_reg_file_sb;

   logic       clk = 1'b0;
   logic       reset;
   logic       we_a, we_b, reserve_en, clear_req;
   logic [2:0] waddr_a, waddr_b, raddr_a, raddr_b, reserve_addr;
   logic [7:0] wdata_a, wdata_b;

   logic [7:0] d_oa, d_ob, n_oa, n_ob, z_oa, z_ob;
   logic       d_ba, d_bb, n_ba, n_bb, z_ba, z_bb;
   logic       d_cb, n_cb, z_cb;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.W(8), .D(3), .ZERO_REG(0), .BYPASS(1)) u_dut (
      .clk_i(clk), .reset_i(reset),
      .we_a_i(we_a), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a),
      .we_b_i(we_b), .waddr_b_i(waddr_b), .wdata_b_i(wdata_b),
      .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
      .out_a_o(d_oa), .out_b_o(d_ob),
      .reserve_en_i(reserve_en), .reserve_addr_i(reserve_addr),
      .busy_a_o(d_ba), .busy_b_o(d_bb),
      .clear_req_i(clear_req), .clear_busy_o(d_cb));

   reg_file_sb #(.W(8), .D(3), .ZERO_REG(0), .BYPASS(0)) u_nb (
      .clk_i(clk), .reset_i(reset),
      .we_a_i(we_a), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a),
      .we_b_i(we_b), .waddr_b_i(waddr_b), .wdata_b_i(wdata_b),
      .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
      .out_a_o(n_oa), .out_b_o(n_ob),
      .reserve_en_i(reserve_en), .reserve_addr_i(reserve_addr),
      .busy_a_o(n_ba), .busy_b_o(n_bb),
      .clear_req_i(clear_req), .clear_busy_o(n_cb));

   reg_file_sb #(.W(8), .D(3), .ZERO_REG(1), .BYPASS(1)) u_zr (
      .clk_i(clk), .reset_i(reset),
      .we_a_i(we_a), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a),
      .we_b_i(we_b), .waddr_b_i(waddr_b), .wdata_b_i(wdata_b),
      .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
      .out_a_o(z_oa), .out_b_o(z_ob),
      .reserve_en_i(reserve_en), .reserve_addr_i(reserve_addr),
      .busy_a_o(z_ba), .busy_b_o(z_bb),
      .clear_req_i(clear_req), .clear_busy_o(z_cb));

   typedef struct packed {
      logic       we_a;
      logic [2:0] wa;
      logic [7:0] wda;
      logic       we_b;
      logic [2:0] wb;
      logic [7:0] wdb;
      logic [2:0] ra;
      logic [2:0] rb;
      logic       re;
      logic [2:0] rad;
      logic [7:0] ea;   // bypass instance expectations
      logic [7:0] eb;
      logic       eba;
      logic       ebb;
      logic [7:0] na;   // no-bypass instance expectations
      logic [7:0] nb;
      logic       nba;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic idle_in();
      we_a = 1'b0; waddr_a = '0; wdata_a = '0;
      we_b = 1'b0; waddr_b = '0; wdata_b = '0;
      reserve_en = 1'b0; reserve_addr = '0; clear_req = 1'b0;
   endtask

   int sweep_cnt;

   initial begin
      vecs[0]  = '{1'b1,3'd3,8'h5A, 1'b1,3'd3,8'h11, 3'd3,3'd3, 1'b0,3'd0, 8'h5A,8'h5A,1'b0,1'b0, 8'h00,8'h00,1'b0};
      vecs[1]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd3,3'd0, 1'b0,3'd0, 8'h5A,8'h00,1'b0,1'b0, 8'h5A,8'h00,1'b0};
      vecs[2]  = '{1'b1,3'd2,8'hC3, 1'b0,3'd0,8'h00, 3'd3,3'd2, 1'b0,3'd0, 8'h5A,8'hC3,1'b0,1'b0, 8'h5A,8'h00,1'b0};
      vecs[3]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd5,3'd2, 1'b1,3'd5, 8'h00,8'hC3,1'b0,1'b0, 8'h00,8'hC3,1'b0};
      vecs[4]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd5,3'd2, 1'b0,3'd0, 8'h00,8'hC3,1'b1,1'b0, 8'h00,8'hC3,1'b1};
      vecs[5]  = '{1'b0,3'd0,8'h00, 1'b1,3'd5,8'h7E, 3'd5,3'd2, 1'b0,3'd0, 8'h7E,8'hC3,1'b0,1'b0, 8'h00,8'hC3,1'b1};
      vecs[6]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd5,3'd2, 1'b0,3'd0, 8'h7E,8'hC3,1'b0,1'b0, 8'h7E,8'hC3,1'b0};
      vecs[7]  = '{1'b1,3'd6,8'h99, 1'b0,3'd0,8'h00, 3'd6,3'd5, 1'b1,3'd6, 8'h99,8'h7E,1'b0,1'b0, 8'h00,8'h7E,1'b0};
      vecs[8]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd6,3'd5, 1'b0,3'd0, 8'h99,8'h7E,1'b1,1'b0, 8'h99,8'h7E,1'b1};
      vecs[9]  = '{1'b1,3'd1,8'h12, 1'b1,3'd4,8'h34, 3'd4,3'd1, 1'b0,3'd0, 8'h34,8'h12,1'b0,1'b0, 8'h00,8'h00,1'b0};
      vecs[10] = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd1,3'd4, 1'b0,3'd0, 8'h12,8'h34,1'b0,1'b0, 8'h12,8'h34,1'b0};

      reset = 1'b1;
      idle_in();
      raddr_a = '0; raddr_b = '0;
      @(negedge clk);
      reset = 1'b0;

      // Reset state across every address
      for (int a = 0; a < 8; a++) begin
         raddr_a = 3'(a); raddr_b = 3'(7 - a);
         #1;
         chk("rst_out_a", d_oa, 8'h00);
         chk("rst_out_b", d_ob, 8'h00);
         chk("rst_busy", {6'd0, d_ba, d_bb}, 8'h00);
         chk("rst_clear_busy", {5'd0, d_cb, n_cb, z_cb}, 8'h00);
         @(negedge clk);
      end

      // Vector table: one cycle per record
      for (int v = 0; v < 11; v++) begin
         we_a = vecs[v].we_a; waddr_a = vecs[v].wa; wdata_a = vecs[v].wda;
         we_b = vecs[v].we_b; waddr_b = vecs[v].wb; wdata_b = vecs[v].wdb;
         raddr_a = vecs[v].ra; raddr_b = vecs[v].rb;
         reserve_en = vecs[v].re; reserve_addr = vecs[v].rad;
         #1;
         chk($sformatf("v%0d_out_a", v), d_oa, vecs[v].ea);
         chk($sformatf("v%0d_out_b", v), d_ob, vecs[v].eb);
         chk($sformatf("v%0d_busy_a", v), {7'd0, d_ba}, {7'd0, vecs[v].eba});
         chk($sformatf("v%0d_busy_b", v), {7'd0, d_bb}, {7'd0, vecs[v].ebb});
         chk($sformatf("v%0d_nb_out_a", v), n_oa, vecs[v].na);
         chk($sformatf("v%0d_nb_out_b", v), n_ob, vecs[v].nb);
         chk($sformatf("v%0d_nb_busy_a", v), {7'd0, n_ba}, {7'd0, vecs[v].nba});
         chk($sformatf("v%0d_zr_out_a", v), z_oa, vecs[v].ea);
         @(negedge clk);
      end

      // Clear sweep: fill, reserve r3, then pulse CLEAR_REQ
      idle_in();
      for (int a = 0; a < 8; a++) begin
         we_a = 1'b1; waddr_a = 3'(a); wdata_a = 8'hFF;
         @(negedge clk);
      end
      idle_in();
      reserve_en = 1'b1; reserve_addr = 3'd3;
      @(negedge clk);
      idle_in();
      clear_req = 1'b1; raddr_a = 3'd3;
      #1;
      chk("pre_sweep_busy_r3", {7'd0, d_ba}, 8'h01);
      chk("pre_sweep_clear_busy", {7'd0, d_cb}, 8'h00);
      sweep_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         idle_in();
         if (i < 8) begin
            we_a = 1'b1; waddr_a = 3'd7; wdata_a = 8'h55;
            we_b = 1'b1; waddr_b = 3'(i); wdata_b = 8'h33;
            reserve_en = 1'b1; reserve_addr = 3'd2;
         end
         raddr_a = 3'd7; raddr_b = 3'd3;
         #1;
         if (d_cb) sweep_cnt++;
         if (i == 0) begin
            chk("sweep_no_bypass", d_oa, 8'hFF);
            chk("sweep_busy_unswept", {7'd0, d_bb}, 8'h01);
         end
         if (i == 4) begin
            chk("sweep_swept_out", d_ob, 8'h00);
            chk("sweep_swept_busy", {7'd0, d_bb}, 8'h00);
         end
      end
      chk("sweep_cycles", 8'(sweep_cnt), 8'd8);
      for (int a = 0; a < 8; a++) begin
         @(negedge clk);
         raddr_a = 3'(a); raddr_b = 3'(a);
         #1;
         chk($sformatf("post_sweep_out_r%0d", a), d_oa, 8'h00);
         chk($sformatf("post_sweep_busy_r%0d", a), {6'd0, d_ba, n_bb}, 8'h00);
      end

      // Hardwired r0: write and reserve are both dropped
      @(negedge clk);
      idle_in();
      we_a = 1'b1; waddr_a = 3'd0; wdata_a = 8'hAA;
      reserve_en = 1'b1; reserve_addr = 3'd0;
      raddr_a = 3'd0; raddr_b = 3'd0;
      #1;
      chk("zr_out_same_cycle", z_oa, 8'h00);
      chk("zr_busy_same_cycle", {7'd0, z_ba}, 8'h00);
      chk("byp_r0_same_cycle", d_oa, 8'hAA);
      @(negedge clk);
      idle_in();
      #1;
      chk("zr_out_r0", z_oa, 8'h00);
      chk("zr_busy_r0", {7'd0, z_ba}, 8'h00);
      chk("dflt_out_r0", d_oa, 8'hAA);
      chk("dflt_busy_r0", {7'd0, d_ba}, 8'h01);

      // Reset in the middle of a sweep
      @(negedge clk);
      we_a = 1'b1; waddr_a = 3'd5; wdata_a = 8'h42;
      @(negedge clk);
      idle_in();
      clear_req = 1'b1;
      repeat (3) @(negedge clk);
      clear_req = 1'b0;
      #1;
      chk("mid_sweep_active", {7'd0, d_cb}, 8'h01);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      raddr_a = 3'd5; raddr_b = 3'd0;
      #1;
      chk("abort_clear_busy", {5'd0, d_cb, n_cb, z_cb}, 8'h00);
      chk("abort_out_r5", d_oa, 8'h00);
      chk("abort_nb_out_r5", n_oa, 8'h00);
      chk("abort_busy_r0", {7'd0, d_bb}, 8'h00);
      repeat (2) @(negedge clk);
      #1;
      chk("abort_stays_idle", {5'd0, d_cb, n_cb, z_cb}, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
